// File: rtl/game_report_tx.sv
// game_report_tx
//   Sends a fixed 7-byte game status frame to the UART transmitter byte
//   interface. A frame goes out once after reset and whenever any reported
//   field differs from the values carried by the last frame.
//   Frame: HEADER, {6'b0,state}, mole_score, {4'b0,left_time[11:8]},
//          left_time[7:0], {4'b0,mole_find}, 8-bit wrapping checksum of bytes 0..5.
//   Optional feature macro: REPORT_HEARTBEAT_EN. When it is defined, a
//   frame is also sent after PERIOD_MS of silence.
//
// Ports
//   clk, rst           system clock, synchronous active-high reset
//   state, mole_score, mole_find, left_time   game status inputs
//   tx_data, tx_data_valid, tx_data_ready     byte handshake to uart_tx
//   busy               frame or trailing gap in progress
//   frame_cnt          completed frames, wraps 255 -> 0
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a trigger (boot, field change, heartbeat)
//   SEND   | presenting frame byte byte_idx from the snapshot
//   GAP    | forced idle clocks after a frame
module game_report_tx #(
  parameter int         CLK_FRE    = 27,
  parameter int         GAP_CYCLES = 16,
  parameter logic [7:0] HEADER     = 8'hA5,
  parameter int         PERIOD_MS  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic [7:0]  mole_score,
  input  logic [3:0]  mole_find,
  input  logic [11:0] left_time,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam longint HB_CYCLES = longint'(CLK_FRE) * 1000 * longint'(PERIOD_MS);

  if (GAP_CYCLES < 1 || HB_CYCLES < 1) begin : g_bad_param
    $error("game_report_tx: GAP_CYCLES and heartbeat period must be at least 1");
  end

  logic [1:0]       fsm_q, fsm_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             pending_boot_q, pending_boot_d;
  logic [1:0]       snap_state_q, snap_state_d;
  logic [7:0]       snap_score_q, snap_score_d;
  logic [3:0]       snap_find_q, snap_find_d;
  logic [11:0]      snap_time_q, snap_time_d;

  logic       hb_trig;
  logic       trigger;
  logic       frame_start;
  logic [7:0] checksum;
  logic [7:0] frame_byte;

  assign trigger = pending_boot_q | hb_trig |
                   (state != snap_state_q) | (mole_score != snap_score_q) |
                   (left_time != snap_time_q) | (mole_find != snap_find_q);
  assign frame_start = (fsm_q == S_IDLE) && trigger;

  assign checksum = HEADER + {6'b0, snap_state_q} + snap_score_q +
                    {4'b0, snap_time_q[11:8]} + snap_time_q[7:0] + {4'b0, snap_find_q};

  always_comb begin
    frame_byte = checksum;
    case (byte_idx_q)
      3'd0: frame_byte = HEADER;
      3'd1: frame_byte = {6'b0, snap_state_q};
      3'd2: frame_byte = snap_score_q;
      3'd3: frame_byte = {4'b0, snap_time_q[11:8]};
      3'd4: frame_byte = snap_time_q[7:0];
      3'd5: frame_byte = {4'b0, snap_find_q};
      default: frame_byte = checksum;
    endcase
  end

  always_comb begin
    fsm_d          = fsm_q;
    byte_idx_d     = byte_idx_q;
    gap_cnt_d      = gap_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    pending_boot_d = pending_boot_q;
    snap_state_d   = snap_state_q;
    snap_score_d   = snap_score_q;
    snap_find_d    = snap_find_q;
    snap_time_d    = snap_time_q;
    case (fsm_q)
      S_IDLE: begin
        if (frame_start) begin
          snap_state_d   = state;
          snap_score_d   = mole_score;
          snap_find_d    = mole_find;
          snap_time_d    = left_time;
          pending_boot_d = 1'b0;
          byte_idx_d     = 3'd0;
          fsm_d          = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_data_ready) begin
          if (byte_idx_q == 3'd6) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            gap_cnt_d   = GAP_LOAD;
            fsm_d       = S_GAP;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          fsm_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q          <= S_IDLE;
      byte_idx_q     <= 3'd0;
      gap_cnt_q      <= '0;
      frame_cnt_q    <= 8'd0;
      pending_boot_q <= 1'b1;
      snap_state_q   <= 2'd0;
      snap_score_q   <= 8'd0;
      snap_find_q    <= 4'd0;
      snap_time_q    <= 12'd0;
    end else begin
      fsm_q          <= fsm_d;
      byte_idx_q     <= byte_idx_d;
      gap_cnt_q      <= gap_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      pending_boot_q <= pending_boot_d;
      snap_state_q   <= snap_state_d;
      snap_score_q   <= snap_score_d;
      snap_find_q    <= snap_find_d;
      snap_time_q    <= snap_time_d;
    end
  end

`ifdef REPORT_HEARTBEAT_EN
  localparam logic [31:0] HB_LOAD = 32'(HB_CYCLES - 1);
  logic [31:0] hb_cnt_q, hb_cnt_d;
  logic        hb_req_q, hb_req_d;
  logic        hb_wrap;

  // The wrap itself counts as a request so frame starts are spaced by
  // exactly the heartbeat period; a frame start restarts the period.
  always_comb begin
    hb_wrap  = (hb_cnt_q == 32'd0);
    hb_cnt_d = hb_wrap ? HB_LOAD : hb_cnt_q - 32'd1;
    hb_req_d = hb_req_q | hb_wrap;
    if (frame_start) begin
      hb_cnt_d = HB_LOAD;
      hb_req_d = 1'b0;
    end
  end

  assign hb_trig = hb_req_q | hb_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= HB_LOAD;
      hb_req_q <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_req_q <= hb_req_d;
    end
  end
`else
  assign hb_trig = 1'b0;
`endif

  assign busy          = (fsm_q != S_IDLE);
  assign tx_data_valid = (fsm_q == S_SEND);
  assign tx_data       = (fsm_q == S_SEND) ? frame_byte : 8'd0;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_game_report_tx.sv
module tb_game_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic [7:0]  mole_score;
  logic [3:0]  mole_find;
  logic [11:0] left_time;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        busy;
  logic [7:0]  frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  game_report_tx dut (
    .clk           (clk),
    .rst           (rst),
    .state         (state),
    .mole_score    (mole_score),
    .mole_find     (mole_find),
    .left_time     (left_time),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) for valid, then checks all 7 bytes with ready high,
  // optionally holding ready low for stall_len clocks at byte stall_idx.
  task automatic recv_frame(input string tag, input logic [55:0] exp,
                            input int stall_idx, input int stall_len, output int waited);
    logic [7:0] b;
    waited = 0;
    while (tx_data_valid !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    if (tx_data_valid !== 1'b1) begin
      chk($sformatf("%s start timeout", tag), 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < 7; i++) begin
      b = exp[55-8*i -: 8];
      if (i == stall_idx) begin
        tx_data_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk($sformatf("%s stall%0d", tag, k), {23'd0, tx_data_valid, tx_data}, {24'd1, b});
        end
        tx_data_ready = 1'b1;
      end
      chk($sformatf("%s byte%0d", tag, i), {23'd0, tx_data_valid, tx_data}, {24'd1, b});
      step();
    end
    chk($sformatf("%s valid_drop", tag), {31'd0, tx_data_valid}, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    chk($sformatf("%s idle", tag), {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (tx_data_valid === 1'b1) seen++;
    end
    chk($sformatf("%s quiet", tag), seen, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    state = 2'd0;
    mole_score = 8'd0;
    mole_find = 4'd0;
    left_time = 12'd300;
    tx_data_ready = 1'b1;
    step();
    step();
    chk("rst valid", {31'd0, tx_data_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("rst tx_data", {24'd0, tx_data}, 32'd0);

    // Boot frame
    rst = 1'b0;
    recv_frame("boot", 56'hA5_00_00_01_2C_00_D2, -1, 0, w);
    chk("boot latency", w, 32'd1);
    chk("boot frame_cnt", {24'd0, frame_cnt}, 32'd1);
    chk("boot busy_gap", {31'd0, busy}, 32'd1);
    wait_idle("boot");
    quiet("boot", 40);

    // State then score change
    state = 2'd2;
    recv_frame("state", 56'hA5_02_00_01_2C_00_D4, -1, 0, w);
    chk("state latency", w, 32'd1);
    wait_idle("state");
    mole_score = 8'd1;
    recv_frame("score", 56'hA5_02_01_01_2C_00_D5, -1, 0, w);
    chk("score latency", w, 32'd1);
    chk("score frame_cnt", {24'd0, frame_cnt}, 32'd3);
    wait_idle("score");

    // Backpressure on byte 3 for 10 clocks
    left_time = 12'h150;
    recv_frame("bp", 56'hA5_02_01_01_50_00_F9, 3, 10, w);
    wait_idle("bp");

    // Coalescing: score 1->2 mid-frame, 2->3 during gap
    mole_find = 4'd5;
    step();
    mole_score = 8'd2;
    recv_frame("coalA", 56'hA5_02_01_01_50_05_FE, -1, 0, w);
    chk("coalA latency", w, 32'd0);
    mole_score = 8'd3;
    recv_frame("coalB", 56'hA5_02_03_01_50_05_00, -1, 0, w);
    chk("coalB gap", w, 32'd17);
    wait_idle("coalB");
    quiet("coalB", 60);
    chk("coal frame_cnt", {24'd0, frame_cnt}, 32'd6);

    // Mid-frame reset at byte 4
    mole_find = 4'd7;
    w = 0;
    while (tx_data_valid !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    for (int i = 0; i < 4; i++) step();
    chk("mid byte4", {23'd0, tx_data_valid, tx_data}, {24'd1, 8'h50});
    rst = 1'b1;
    step();
    chk("mid valid", {31'd0, tx_data_valid}, 32'd0);
    chk("mid frame_cnt", {24'd0, frame_cnt}, 32'd0);
    chk("mid busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    recv_frame("reboot", 56'hA5_02_03_01_50_07_02, -1, 0, w);
    chk("reboot latency", w, 32'd1);
    chk("reboot frame_cnt", {24'd0, frame_cnt}, 32'd1);
    wait_idle("reboot");

    // Out-of-range mole_find passes through
    mole_find = 4'd15;
    recv_frame("find15", 56'hA5_02_03_01_50_0F_0A, -1, 0, w);
    chk("find15 frame_cnt", {24'd0, frame_cnt}, 32'd2);
    wait_idle("find15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
